// File: rtl/dw_conv_sched.sv
// Depthwise 3x3 convolution window scheduler: walks output positions (oh, ow, ch),
// emits one window command per step with its padding mask, and throttles on outstanding results.
module dw_conv_sched #(
   parameter int DIM_W        = 8,
   parameter int CH_W         = 10,
   parameter int MAX_INFLIGHT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [DIM_W-1:0] cfg_h,
   input  logic [DIM_W-1:0] cfg_w,
   input  logic [CH_W-1:0]  cfg_c,
   input  logic             cfg_stride2,
   output logic             busy,
   output logic             done,
   output logic             cfg_err,
   output logic             cmd_valid,
   input  logic             cmd_ready,
   output logic [DIM_W-1:0] cmd_row,
   output logic [DIM_W-1:0] cmd_col,
   output logic [CH_W-1:0]  cmd_ch,
   output logic [8:0]       cmd_pad_mask,
   output logic             cmd_last,
   input  logic             rsp_fire
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

   localparam logic [3:0] MAX_IF = 4'(MAX_INFLIGHT);

   state_t           state_q, state_d;
   logic [DIM_W-1:0] h_q, h_d, w_q, w_d;
   logic [DIM_W-1:0] ohmax_q, ohmax_d, owmax_q, owmax_d;
   logic [DIM_W-1:0] oh_q, oh_d, ow_q, ow_d;
   logic [CH_W-1:0]  cmax_q, cmax_d, ch_q, ch_d;
   logic             s2_q, s2_d;
   logic [3:0]       infl_q, infl_d;
   logic             done_q, done_d, err_q, err_d;

   logic             issue, valid_w, fire, rsp_ok, cfg_ok;
   logic             ch_wrap, ow_wrap, oh_wrap, last_pos;
   logic [DIM_W-1:0] row, col;
   logic [2:0]       row_out, col_out;
   logic [8:0]       mask;

   assign cfg_ok  = (cfg_h != '0) && (cfg_w != '0) && (cfg_c != '0);
   assign issue   = (state_q == S_ISSUE);
   assign valid_w = issue && (infl_q < MAX_IF);
   assign fire    = valid_w && cmd_ready;
   assign rsp_ok  = rsp_fire && (infl_q != 4'd0);

   assign ch_wrap  = (ch_q == cmax_q);
   assign ow_wrap  = (ow_q == owmax_q);
   assign oh_wrap  = (oh_q == ohmax_q);
   assign last_pos = ch_wrap && ow_wrap && oh_wrap;

   assign row = s2_q ? {oh_q[DIM_W-2:0], 1'b0} : oh_q;
   assign col = s2_q ? {ow_q[DIM_W-2:0], 1'b0} : ow_q;

   // Centre never leaves the map, so only the first/last row and column can spill over.
   assign row_out = {(row == h_q - DIM_W'(1)), 1'b0, (row == '0)};
   assign col_out = {(col == w_q - DIM_W'(1)), 1'b0, (col == '0)};

   always_comb begin
      mask = '0;
      for (int ky = 0; ky < 3; ky++) begin
         for (int kx = 0; kx < 3; kx++) begin
            mask[ky*3+kx] = row_out[ky] | col_out[kx];
         end
      end
   end

   always_comb begin
      infl_d = infl_q;
      if (fire && !rsp_ok)      infl_d = infl_q + 4'd1;
      else if (!fire && rsp_ok) infl_d = infl_q - 4'd1;
   end

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      w_d     = w_q;
      cmax_d  = cmax_q;
      s2_d    = s2_q;
      ohmax_d = ohmax_q;
      owmax_d = owmax_q;
      oh_d    = oh_q;
      ow_d    = ow_q;
      ch_d    = ch_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_ok) begin
                  h_d     = cfg_h;
                  w_d     = cfg_w;
                  cmax_d  = cfg_c - CH_W'(1);
                  s2_d    = cfg_stride2;
                  // (n+1)/2 - 1 == (n-1)/2 for n >= 1
                  ohmax_d = cfg_stride2 ? (cfg_h - DIM_W'(1)) >> 1 : cfg_h - DIM_W'(1);
                  owmax_d = cfg_stride2 ? (cfg_w - DIM_W'(1)) >> 1 : cfg_w - DIM_W'(1);
                  oh_d    = '0;
                  ow_d    = '0;
                  ch_d    = '0;
                  state_d = S_ISSUE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (fire) begin
               if (last_pos) begin
                  state_d = S_DRAIN;
               end else if (!ch_wrap) begin
                  ch_d = ch_q + CH_W'(1);
               end else begin
                  ch_d = '0;
                  if (!ow_wrap) begin
                     ow_d = ow_q + DIM_W'(1);
                  end else begin
                     ow_d = '0;
                     oh_d = oh_q + DIM_W'(1);
                  end
               end
            end
         end
         S_DRAIN: begin
            if (infl_d == 4'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         h_q     <= '0;
         w_q     <= '0;
         cmax_q  <= '0;
         s2_q    <= 1'b0;
         ohmax_q <= '0;
         owmax_q <= '0;
         oh_q    <= '0;
         ow_q    <= '0;
         ch_q    <= '0;
         infl_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         w_q     <= w_d;
         cmax_q  <= cmax_d;
         s2_q    <= s2_d;
         ohmax_q <= ohmax_d;
         owmax_q <= owmax_d;
         oh_q    <= oh_d;
         ow_q    <= ow_d;
         ch_q    <= ch_d;
         infl_q  <= infl_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign cfg_err      = err_q;
   assign cmd_valid    = valid_w;
   assign cmd_row      = issue ? row : '0;
   assign cmd_col      = issue ? col : '0;
   assign cmd_ch       = issue ? ch_q : '0;
   assign cmd_pad_mask = issue ? mask : '0;
   assign cmd_last     = issue && last_pos;

endmodule
